set_key_conditioner: RTL

Front end for the clock's minute-setting path. It synchronizes and debounces the two raw set push-buttons, optionally auto-repeats them while held, and emits clean single-cycle `set_L` / `set_H` pulses. These pulses drive the minute-digit setter that sits directly downstream. Each pulse means "advance this digit by one".

---
 rtl/clock_pkg.sv | 22 ++
 rtl/set_key_channel.sv | 112 +++++++++++
 rtl/set_key_conditioner.sv | 76 +++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types for the clock's set-key front end: key FSM states and counter sizing.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } key_state_t;

  // One counter serves every timing phase, so size it for the longest one plus a spare bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return 32'($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/set_key_channel.sv
// One set key: 2-flop synchronizer, debounce/auto-repeat FSM, raw pulse and held level.
// Auto-repeat is built only when SET_KEY_AUTOREPEAT_EN is defined.
module set_key_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 20000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 500000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pulse_c,
  output logic o_held_c
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  key_state_t    r_state;
  key_state_t    w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state, counter and raw pulse; pulse is decided on the transition so the top can register it.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    o_pulse_c  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (r_sync2) w_state_nx = PRESS_DB;
      end
      PRESS_DB: begin
        if (!r_sync2) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
          o_pulse_c  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nx = REL_DB;
          w_cnt_nx   = '0;
`ifdef SET_KEY_AUTOREPEAT_EN
        end else if (r_cnt == CW'(REPEAT_DELAY_CYCLES - 1)) begin
          w_state_nx = REPEAT;
          w_cnt_nx   = '0;
          o_pulse_c  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
`endif
        end
      end
`ifdef SET_KEY_AUTOREPEAT_EN
      REPEAT: begin
        if (!r_sync2) begin
          w_state_nx = REL_DB;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(REPEAT_RATE_CYCLES - 1)) begin
          w_cnt_nx  = '0;
          o_pulse_c = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
`endif
      REL_DB: begin
        if (r_sync2) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Held follows the next state so it rises together with the registered press pulse.
  always_comb begin
    o_held_c = (w_state_nx == HELD) || (w_state_nx == REPEAT) || (w_state_nx == REL_DB);
  end

endmodule

// File: rtl/set_key_conditioner.sv
// Minute-set key front end: two debounced key channels merged into mutually exclusive pulses.
// Auto-repeat is enabled by defining SET_KEY_AUTOREPEAT_EN.
module set_key_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 20000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 500000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_L,
  input  logic key_H,
  output logic set_L,
  output logic set_H,
  output logic held_L,
  output logic held_H
);

  logic w_pulse_L;
  logic w_pulse_H;
  logic w_held_L;
  logic w_held_H;
  logic r_set_L;
  logic r_set_H;
  logic r_held_L;
  logic r_held_H;
  logic r_pend;

  set_key_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
  ) u_ch_L (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key    (key_L),
    .o_pulse_c(w_pulse_L),
    .o_held_c (w_held_L)
  );

  set_key_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
  ) u_ch_H (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key    (key_H),
    .o_pulse_c(w_pulse_H),
    .o_held_c (w_held_H)
  );

  // Low digit wins a collision; the high pulse waits one cycle in r_pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_set_L  <= 1'b0;
      r_set_H  <= 1'b0;
      r_held_L <= 1'b0;
      r_held_H <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_set_L  <= w_pulse_L;
      r_set_H  <= (w_pulse_H & ~w_pulse_L) | r_pend;
      r_pend   <= w_pulse_H & w_pulse_L;
      r_held_L <= w_held_L;
      r_held_H <= w_held_H;
    end
  end

  assign set_L  = r_set_L;
  assign set_H  = r_set_H;
  assign held_L = r_held_L;
  assign held_H = r_held_H;

endmodule
